// File: rtl/hex2bcd_if.sv
// Handshake/result bundle for the iterative binary-to-BCD converter.
//   start  : request conversion of bin (master -> converter)
//   bin    : unsigned binary value, BIN_W bits (master -> converter)
//   busy   : conversion in progress (converter -> master)
//   done   : one-cycle completion pulse (converter -> master)
//   bcd    : packed BCD result, digit 0 in bcd[3:0] (converter -> master)
//   ovf    : result saturated to all nines (converter -> master)
//   blank  : leading-zero mask, 1 = digit blank (converter -> master)
// The converter uses the slave modport, the requester the master modport.
interface hex2bcd_if #(
  parameter int BIN_W  = 32,
  parameter int DIGITS = 8
);
  logic                  start;
  logic [BIN_W-1:0]      bin;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd;
  logic                  ovf;
  logic [DIGITS-1:0]     blank;

  modport master (
    output start, bin,
    input  busy, done, bcd, ovf, blank
  );

  modport slave (
    input  start, bin,
    output busy, done, bcd, ovf, blank
  );
endinterface

// File: rtl/hex2bcd_seq.sv
// Iterative binary-to-BCD converter (shift-and-add-3 / double dabble).
// One input bit is consumed per clock, so a conversion takes BIN_W cycles
// in SHIFT followed by a one-cycle done pulse. Results saturate to all
// nines when the value does not fit in DIGITS decimal digits.
// Ports:
//   clk : system clock, rising edge
//   rst : synchronous active-high reset, aborts any conversion
//   bus : hex2bcd_if slave modport (start/bin in; busy/done/bcd/ovf/blank out)
// Parameters:
//   BIN_W  : binary input width (4..64)
//   DIGITS : BCD digits produced (1..16)
// Configuration macro:
//   HEX2BCD_BLANK_EN : when defined, blank carries the leading-zero mask;
//                      otherwise blank is tied to zero.
module hex2bcd_seq #(
  parameter int BIN_W  = 32,
  parameter int DIGITS = 8
) (
  input  logic      clk,
  input  logic      rst,
  hex2bcd_if.slave  bus
);
  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(BIN_W - 1);
  localparam logic [BCD_W-1:0] ALL_NINES = {DIGITS{4'h9}};

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t             state_q, state_d;
  logic [BIN_W-1:0]   bin_q, bin_d;
  logic [BCD_W-1:0]   scratch_q, scratch_d;
  logic               sticky_q, sticky_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               done_q, done_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic               ovf_q, ovf_d;
  logic [BCD_W-1:0]   adjusted;
  logic               accept;

  // start is only honoured when no conversion is running
  assign accept = bus.start && (state_q != SHIFT);

  // Add-3 correction: any digit >= 5 would become >= 10 after doubling,
  // so it is pre-biased to carry correctly into the next digit.
  always_comb begin
    adjusted = scratch_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (scratch_q[4*i +: 4] >= 4'd5) begin
        adjusted[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    bin_d     = bin_q;
    scratch_d = scratch_q;
    sticky_d  = sticky_q;
    cnt_d     = cnt_q;
    done_d    = 1'b0;
    bcd_d     = bcd_q;
    ovf_d     = ovf_q;
    case (state_q)
      IDLE, DONE: begin
        if (accept) begin
          state_d   = SHIFT;
          bin_d     = bus.bin;
          scratch_d = '0;
          sticky_d  = 1'b0;
          cnt_d     = '0;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        // {scratch, bin} shifts left; the bit leaving the top digit means
        // the value no longer fits and is remembered until completion
        scratch_d = {adjusted[BCD_W-2:0], bin_q[BIN_W-1]};
        bin_d     = {bin_q[BIN_W-2:0], 1'b0};
        sticky_d  = sticky_q | adjusted[BCD_W-1];
        cnt_d     = cnt_q + 1'b1;
        if (cnt_q == LAST_CNT) begin
          state_d = DONE;
          done_d  = 1'b1;
          ovf_d   = sticky_d;
          bcd_d   = sticky_d ? ALL_NINES : scratch_d;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      bin_q     <= '0;
      scratch_q <= '0;
      sticky_q  <= 1'b0;
      cnt_q     <= '0;
      done_q    <= 1'b0;
      bcd_q     <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bin_q     <= bin_d;
      scratch_q <= scratch_d;
      sticky_q  <= sticky_d;
      cnt_q     <= cnt_d;
      done_q    <= done_d;
      bcd_q     <= bcd_d;
      ovf_q     <= ovf_d;
    end
  end

`ifdef HEX2BCD_BLANK_EN
  logic [DIGITS-1:0] blank_q, blank_d;

  // A digit is blank when it and every digit above it are zero; digit 0
  // is never blank so a zero result still shows one "0".
  function automatic logic [DIGITS-1:0] leading_mask(input logic [BCD_W-1:0] value);
    logic [DIGITS-1:0] mask;
    logic              any_nz;
    mask   = '0;
    any_nz = 1'b0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      any_nz  = any_nz | (|value[4*i +: 4]);
      mask[i] = ~any_nz;
    end
    return mask;
  endfunction

  always_comb begin
    blank_d = blank_q;
    if (done_d) begin
      blank_d = ovf_d ? '0 : leading_mask(bcd_d);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      blank_q <= '0;
    end else begin
      blank_q <= blank_d;
    end
  end

  assign bus.blank = blank_q;
`else
  assign bus.blank = '0;
`endif

  assign bus.busy = (state_q == SHIFT);
  assign bus.done = done_q;
  assign bus.bcd  = bcd_q;
  assign bus.ovf  = ovf_q;
endmodule
